// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and helpers for the clock-enable divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  // Default counter / divisor width (enough for 1 Hz from 100 MHz).
  localparam int DEF_CNT_W = 27;

  // Terminal counts for the standard consumers of the bank.
  localparam logic [DEF_CNT_W-1:0] DIV_SSD_REFRESH = 27'd100000;
  localparam logic [DEF_CNT_W-1:0] DIV_SLOW        = 27'd10000000;

  // Width of the channel-select field; a single channel still needs one bit.
  function automatic int ch_w_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank_if
// Description : Valid/ready divisor configuration port of the divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int CH_W  = 1,
  parameter int CNT_W = DEF_CNT_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_div, output cfg_ready);

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel: counter, active/shadow divisor, pending
//               flag, registered tick pulse and 50% divided level.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan #(
  parameter int               CNT_W   = 27,
  parameter logic [CNT_W-1:0] DEF_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             div_out,
  output logic             pending
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_div_out;
  logic             w_terminal;

  // >= rather than == so a divisor lowered below the count still terminates.
  assign w_terminal = (r_cnt >= r_div);

  // Counter, divisor hand-over and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div     <= DEF_DIV;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_div_out <= 1'b0;
    end else if (!en) begin
      // Idle: no period is in flight, so any new divisor can land at once.
      r_cnt  <= '0;
      r_tick <= 1'b0;
      if (load) begin
        r_div     <= load_div;
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_div     <= r_shadow;
        r_pending <= 1'b0;
      end
    end else begin
      if (w_terminal) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_div_out <= ~r_div_out;
        if (r_pending) begin
          r_div <= r_shadow;
        end
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
      // A value accepted on a terminal edge waits for the following one.
      if (load) begin
        r_shadow  <= load_div;
        r_pending <= 1'b1;
      end else if (w_terminal) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign tick    = r_tick;
  assign div_out = r_div_out;
  assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Multi-channel programmable tick / divided-level generator with
//               a valid/ready divisor reprogramming port.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH  = 2,
  parameter int                      CNT_W   = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {DIV_SSD_REFRESH, DIV_SLOW},
  parameter int                      CH_W    = ch_w_for(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] pending
);

  logic              w_busy;
  logic              w_ready;
  logic [NUM_CH-1:0] w_load;

  // Selected channel's pending flag; out-of-range selects are never busy.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        w_busy = pending[i];
      end
    end
  end

  assign w_ready       = rst_n & ~w_busy;
  assign cfg.cfg_ready = w_ready;

  // Route an accepted request to its channel; out-of-range ones go nowhere.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_load[i] = cfg.cfg_valid & w_ready & (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ch_en[i]),
      .load     (w_load[i]),
      .load_div (cfg.cfg_div),
      .tick     (tick[i]),
      .div_out  (div_out[i]),
      .pending  (pending[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Directed self-checking bench for clk_div_bank (2 channels,
//               8-bit counters, reset divisors ch0=2, ch1=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  localparam int          NUM_CH  = 2;
  localparam int          CNT_W   = 8;
  localparam int          CH_W    = 2;
  localparam logic [15:0] DEF_DIV = {8'd4, 8'd2};

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_out;
  logic [NUM_CH-1:0] pending;

  int checks   = 0;
  int failures = 0;

  clk_div_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .CH_W    (CH_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .cfg     (cfg_if),
    .tick    (tick),
    .div_out (div_out),
    .pending (pending)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, then release with the given enables; next edge is k=1.
  task automatic apply_reset(input logic [1:0] en);
    rst_n            = 1'b0;
    ch_en            = en;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    ch_en            = 2'b11;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    step();
    step();
    checks++; if (tick !== 2'b00)    begin failures++; $display("FAIL reset_tick got=%b exp=00", tick); end
    checks++; if (div_out !== 2'b00) begin failures++; $display("FAIL reset_div_out got=%b exp=00", div_out); end
    checks++; if (pending !== 2'b00) begin failures++; $display("FAIL reset_pending got=%b exp=00", pending); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cfg_if.cfg_ready); end
  endtask

  task automatic test_basic_rates();
    logic [1:0] et, ed;
    apply_reset(2'b11);
    for (int k = 1; k <= 30; k++) begin
      step();
      et = {(k % 5 == 0), (k % 3 == 0)};
      ed = {((k / 5) % 2 == 1), ((k / 3) % 2 == 1)};
      checks++; if (tick !== et)    begin failures++; $display("FAIL basic_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (div_out !== ed) begin failures++; $display("FAIL basic_div_out k=%0d got=%b exp=%b", k, div_out, ed); end
    end
  endtask

  task automatic test_reprogram();
    logic et;
    apply_reset(2'b01);
    for (int k = 1; k <= 7; k++) step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd5;
    #1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL reprog_ready_pre got=%b exp=1", cfg_if.cfg_ready); end
    step(); // k=8: accepted mid-period
    cfg_if.cfg_valid = 1'b0;
    #1;
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL reprog_pending_set got=%b exp=1", pending[0]); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL reprog_ready_busy got=%b exp=0", cfg_if.cfg_ready); end
    checks++; if (tick[0] !== 1'b0) begin failures++; $display("FAIL reprog_tick_k8 got=%b exp=0", tick[0]); end
    step(); // k=9: old period ends, new divisor takes over
    checks++; if (tick[0] !== 1'b1) begin failures++; $display("FAIL reprog_tick_k9 got=%b exp=1", tick[0]); end
    checks++; if (pending[0] !== 1'b0) begin failures++; $display("FAIL reprog_pending_clr got=%b exp=0", pending[0]); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL reprog_ready_post got=%b exp=1", cfg_if.cfg_ready); end
    for (int k = 10; k <= 21; k++) begin
      step();
      et = (k == 15) || (k == 21);
      checks++; if (tick[0] !== et) begin failures++; $display("FAIL reprog_tick k=%0d got=%b exp=%b", k, tick[0], et); end
      checks++; if (tick[1] !== 1'b0) begin failures++; $display("FAIL reprog_ch1_idle k=%0d got=%b exp=0", k, tick[1]); end
    end
  endtask

  task automatic test_disabled_apply();
    logic ed;
    apply_reset(2'b01);
    step(); // k=1
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd1;
    cfg_if.cfg_div   = 8'd0;
    #1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL dis_ready got=%b exp=1", cfg_if.cfg_ready); end
    step(); // k=2: immediate apply
    cfg_if.cfg_valid = 1'b0;
    ch_en            = 2'b11;
    #1;
    checks++; if (pending[1] !== 1'b0) begin failures++; $display("FAIL dis_pending got=%b exp=0", pending[1]); end
    for (int k = 3; k <= 8; k++) begin
      step();
      ed = ((k - 2) % 2 == 1);
      checks++; if (tick[1] !== 1'b1)   begin failures++; $display("FAIL dis_tick k=%0d got=%b exp=1", k, tick[1]); end
      checks++; if (div_out[1] !== ed)  begin failures++; $display("FAIL dis_div_out k=%0d got=%b exp=%b", k, div_out[1], ed); end
      checks++; if (pending[1] !== 1'b0) begin failures++; $display("FAIL dis_pending k=%0d got=%b exp=0", k, pending[1]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] et;
    apply_reset(2'b11);
    step(); // k=1
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd3;
    cfg_if.cfg_div   = 8'd7;
    #1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", cfg_if.cfg_ready); end
    for (int k = 2; k <= 16; k++) begin
      step();
      et = {(k % 5 == 0), (k % 3 == 0)};
      checks++; if (tick !== et)       begin failures++; $display("FAIL oor_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (pending !== 2'b00) begin failures++; $display("FAIL oor_pending k=%0d got=%b exp=00", k, pending); end
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_same_edge();
    logic et, ep;
    apply_reset(2'b01);
    step();
    step(); // k=2, next edge is terminal
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd1;
    step(); // k=3: tick and accept together
    cfg_if.cfg_valid = 1'b0;
    #1;
    checks++; if (tick[0] !== 1'b1)    begin failures++; $display("FAIL same_tick_k3 got=%b exp=1", tick[0]); end
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL same_pending_k3 got=%b exp=1", pending[0]); end
    for (int k = 4; k <= 10; k++) begin
      step();
      et = (k == 6) || (k == 8) || (k == 10);
      ep = (k < 6);
      checks++; if (tick[0] !== et)    begin failures++; $display("FAIL same_tick k=%0d got=%b exp=%b", k, tick[0], et); end
      checks++; if (pending[0] !== ep) begin failures++; $display("FAIL same_pending k=%0d got=%b exp=%b", k, pending[0], ep); end
    end
  endtask

  task automatic test_disable_pending();
    apply_reset(2'b01);
    for (int k = 1; k <= 4; k++) step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd0;
    step(); // k=5: accepted, pending
    cfg_if.cfg_valid = 1'b0;
    ch_en            = 2'b00;
    #1;
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL dpend_set got=%b exp=1", pending[0]); end
    step(); // k=6: disable applies the shadow
    ch_en = 2'b01;
    #1;
    checks++; if (pending[0] !== 1'b0) begin failures++; $display("FAIL dpend_clr got=%b exp=0", pending[0]); end
    checks++; if (tick[0] !== 1'b0)    begin failures++; $display("FAIL dpend_tick_off got=%b exp=0", tick[0]); end
    step();
    checks++; if (tick[0] !== 1'b1) begin failures++; $display("FAIL dpend_tick_k7 got=%b exp=1", tick[0]); end
    step();
    checks++; if (tick[0] !== 1'b1) begin failures++; $display("FAIL dpend_tick_k8 got=%b exp=1", tick[0]); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] et;
    apply_reset(2'b11);
    for (int k = 1; k <= 4; k++) step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd9;
    step(); // k=5
    cfg_if.cfg_valid = 1'b0;
    #1;
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL rmid_pending_pre got=%b exp=1", pending[0]); end
    checks++; if (div_out !== 2'b11)   begin failures++; $display("FAIL rmid_div_out_pre got=%b exp=11", div_out); end
    rst_n = 1'b0;
    step(); // k=6: reset edge
    checks++; if (tick !== 2'b00)    begin failures++; $display("FAIL rmid_tick got=%b exp=00", tick); end
    checks++; if (div_out !== 2'b00) begin failures++; $display("FAIL rmid_div_out got=%b exp=00", div_out); end
    checks++; if (pending !== 2'b00) begin failures++; $display("FAIL rmid_pending got=%b exp=00", pending); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b exp=0", cfg_if.cfg_ready); end
    rst_n = 1'b1;
    for (int k = 7; k <= 12; k++) begin
      step();
      et = {(k == 11), (k == 9) || (k == 12)};
      checks++; if (tick !== et) begin failures++; $display("FAIL rmid_tick k=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    test_reset();
    test_basic_rates();
    test_reprogram();
    test_disabled_apply();
    test_out_of_range();
    test_same_edge();
    test_disable_pending();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable tick/divided-signal generator; next generation of the fixed two-rate display clock generator.
- Produces, per channel, a one-cycle enable pulse (tick) and a 50%-duty divided level (div_out) from the single master clock. Consumers use these as clock enables, never as clocks.
- Divisors are runtime-reprogrammable through a valid/ready config port. Updates apply glitch-free at the channel's next terminal count.
- Feeds the SSD display driver refresh, FSM step rate and any future slow-rate logic.

Parameters:
- NUM_CH, 2, number of independent channels (1..16).
- CNT_W, 27, counter/divisor width in bits.
- DEF_DIV, {27'd100000, 27'd10000000}, packed NUM_CH*CNT_W reset divisor vector; channel i uses slice [i*CNT_W +: CNT_W].
- CH_W, $clog2(NUM_CH) (min 1), config channel-select width.

Ports:
- clk  in  1  master clock, 100 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  CNT_W  new terminal count.
- tick  out  NUM_CH  one-cycle pulse at each terminal count.
- div_out  out  NUM_CH  toggles at each terminal count.
- pending  out  NUM_CH  shadow divisor waiting to be applied.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - all counters 0, tick 0, div_out 0, pending 0.
  - active divisor[i] = DEF_DIV slice i.
  - cfg_ready is 0 while rst_n=0.
- Channel counting, when ch_en[i]=1:
  - count<div: count<=count+1, tick[i]<=0.
  - count>=div (terminal): count<=0, tick[i]<=1 for exactly one cycle, div_out[i]<=~div_out[i].
  - Tick period is div+1 cycles; div_out period is 2*(div+1) cycles.
  - tick and div_out are registered and change on the same edge.
- div=0: tick stays high every cycle while enabled; div_out toggles every cycle.
- ch_en[i]=0: count held at 0, tick[i]=0, div_out[i] holds its last value.
  - After re-enable, the first tick comes div+1 cycles after the first enabled edge.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at a posedge.
  - cfg_ready = rst_n & ~pending[cfg_ch] (combinational on cfg_ch).
  - cfg_ch >= NUM_CH: always ready; the request is accepted and discarded, with no state change.
- Applying a divisor:
  - Enabled channel: cfg_div is written to the shadow register and pending[i]<=1. At the next terminal count the active div<=shadow and pending[i]<=0, on the same edge as the tick. The current period always completes with the old divisor, so there are no runt pulses.
  - Disabled channel: active div<=cfg_div immediately; pending stays 0.
- Simultaneous events:
  - Accept and terminal count on the same edge: the new value becomes shadow and pending=1. It does not apply to the period starting now.
  - Accept and ch_en falling on the same edge: treated as disabled, so immediate apply.
  - ch_en falling while pending=1: shadow applied on that edge, pending cleared.
- Reset mid-operation: all state returns to reset values within one edge, including any pending shadow, which is discarded.
- Width rule: count compare is unsigned CNT_W; count never exceeds div. If div is lowered below the current count (only possible via immediate apply while disabled, where count=0), the >= compare guarantees a terminal count.

Decomposition:
- Package clk_div_pkg: default divisor constants (DIV_SSD_REFRESH=100000, DIV_SLOW=10000000), CNT_W default, and a function returning the CH_W value.
- Sub-module clk_div_chan: one channel holding counter, active and shadow divisor, pending flag, tick and div_out; inputs en, load, load_div.
- clk_div_bank generates NUM_CH instances and does the cfg_ch decode plus the cfg_ready mux.

Test Plan:
1. Instance NUM_CH=2, CNT_W=8, DEF_DIV={8'd4,8'd2}; release reset, ch_en=2'b11 -> tick[0] every 3 cycles, tick[1] every 5; div_out[0] period 6, div_out[1] period 10; first tick[0] 3 cycles after enable.
2. ch0 running at div 2; write cfg_ch=0, cfg_div=5 mid-period -> pending[0]=1 and cfg_ready=0 for cfg_ch=0; the current period ends on the old spacing, then ticks every 6 cycles; pending drops on that tick edge.
3. ch_en[1]=0, write cfg_div=0 to ch1, then re-enable -> immediate apply, pending[1] never set; tick[1] constantly high and div_out[1] toggling every cycle.
4. cfg_valid held with cfg_ch=3 (out of range) -> accepted in one cycle; no change to either channel.
5. Terminal count and config accept on the same edge -> the period that starts uses the old divisor and the next period uses the new one.
6. Assert rst_n=0 for one cycle while pending[0]=1 mid-count -> next cycle: counters 0, tick 0, div_out 0, pending 0, divisors back to DEF_DIV.
